// File: rtl/sd_if_pkg.sv
// Shared constants, FSM encoding and byte-lane helper for the SD-card write path.
package sd_if_pkg;

  localparam logic [31:0] SECTOR_ADDR  = 32'hFFFF0270;
  localparam logic [31:0] CTRL_ADDR    = 32'hFFFF0274;
  localparam logic [31:0] BUF_BASE     = 32'hFFFF0400;
  localparam int          BUF_WORDS    = 128;
  localparam int          SECTOR_BYTES = 512;
  localparam logic [31:0] BUF_SPAN     = 32'(SECTOR_BYTES);
  localparam logic [8:0]  LAST_BYTE    = 9'(SECTOR_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RDY = 2'd1,
    STREAM   = 2'd2,
    FLUSH    = 2'd3
  } sd_state_e;

  // Sector byte 4k+n lives in bits [8n+7:8n] of buffer word k.
  function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] n);
    return word[{n, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/sd_wr_buffer.sv
// 128x32 sector buffer: byte-enabled bus port (read/write) plus a read-only stream port.
module sd_wr_buffer
  import sd_if_pkg::*;
(
  input  logic        iCLK,
  input  logic        bus_we,
  input  logic [3:0]  bus_be,
  input  logic [6:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  input  logic [6:0]  strm_addr,
  output logic [31:0] strm_rdata
);

  // One byte-wide RAM per lane so each lane's write enable stays independent.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem [BUF_WORDS];
    logic [7:0] bus_q;
    logic [7:0] strm_q;

    always_ff @(posedge iCLK) begin
      if (bus_we && bus_be[gi]) begin
        mem[bus_addr] <= bus_wdata[8*gi +: 8];
      end
      bus_q  <= mem[bus_addr];
      strm_q <= mem[strm_addr];
    end

    assign bus_rdata[8*gi +: 8]  = bus_q;
    assign strm_rdata[8*gi +: 8] = strm_q;
  end

endmodule

// File: rtl/sd_write_interface.sv
// Bus-mapped SD write path: CPU fills a 512-byte buffer, then an FSM streams it
// byte-by-byte to the SD controller's single-block write port.
module sd_write_interface
  import sd_if_pkg::*;
(
  input  logic        iCLK,
  input  logic        Reset,
  input  logic        wReadEnable,
  input  logic        wWriteEnable,
  input  logic [3:0]  wByteEnable,
  input  logic [31:0] wAddress,
  input  logic [31:0] wWriteData,
  output logic [31:0] wReadData,
  output logic [31:0] oSDAddress,
  output logic        oSDWrite,
  output logic [7:0]  oSDData,
  input  logic        iSDByteReq,
  input  logic        iSDReady
);

  sd_state_e   state_q, state_d;
  logic [8:0]  ptr_q, ptr_d;
  logic        sd_write_q, sd_write_d;
  logic [7:0]  sd_data_q, sd_data_d;
  logic [31:0] sd_addr_q, sd_addr_d;
  logic        done_q, done_d;
  logic        low_seen_q, low_seen_d;

  logic [31:0] buf_off;
  logic        sel_sector, sel_ctrl, sel_buf;
  logic        busy, buf_we, start;
  logic [31:0] bus_rdata, strm_word;

  assign buf_off    = wAddress - BUF_BASE;
  assign sel_sector = (wAddress == SECTOR_ADDR);
  assign sel_ctrl   = (wAddress == CTRL_ADDR);
  assign sel_buf    = (buf_off < BUF_SPAN);
  assign busy       = (state_q != IDLE);
  assign buf_we     = wWriteEnable && sel_buf && !busy;
  assign start      = wWriteEnable && sel_ctrl && wWriteData[0] && !busy;

  // Stream port is addressed with the next pointer, so strm_word always
  // holds the word of the current pointer one cycle after it changes.
  sd_wr_buffer u_buf (
    .iCLK       (iCLK),
    .bus_we     (buf_we),
    .bus_be     (wByteEnable),
    .bus_addr   (buf_off[8:2]),
    .bus_wdata  (wWriteData),
    .bus_rdata  (bus_rdata),
    .strm_addr  (ptr_d[8:2]),
    .strm_rdata (strm_word)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    sd_write_d = sd_write_q;
    sd_data_d  = sd_data_q;
    sd_addr_d  = sd_addr_q;
    done_d     = done_q;
    low_seen_d = low_seen_q;

    if (wWriteEnable && sel_sector && !busy) begin
      sd_addr_d = wWriteData;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WAIT_RDY;
          ptr_d   = '0;
          done_d  = 1'b0;
        end
      end
      WAIT_RDY: begin
        if (iSDReady) begin
          state_d    = STREAM;
          sd_write_d = 1'b1;
          sd_data_d  = byte_lane(strm_word, ptr_q[1:0]);
        end
      end
      STREAM: begin
        sd_data_d = byte_lane(strm_word, ptr_q[1:0]);
        if (iSDByteReq) begin
          if (ptr_q == LAST_BYTE) begin
            state_d    = FLUSH;
            sd_write_d = 1'b0;
            sd_data_d  = 8'hFF;
            low_seen_d = 1'b0;
          end else begin
            ptr_d = ptr_q + 9'd1;
          end
        end
      end
      FLUSH: begin
        // Controller drops ready while it sends CRC and waits on card busy.
        if (!iSDReady) begin
          low_seen_d = 1'b1;
        end
        if (low_seen_q && iSDReady) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (Reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      sd_write_q <= 1'b0;
      sd_data_q  <= 8'hFF;
      sd_addr_q  <= '0;
      done_q     <= 1'b0;
      low_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      sd_write_q <= sd_write_d;
      sd_data_q  <= sd_data_d;
      sd_addr_q  <= sd_addr_d;
      done_q     <= done_d;
      low_seen_q <= low_seen_d;
    end
  end

  assign oSDAddress = sd_addr_q;
  assign oSDWrite   = sd_write_q;
  assign oSDData    = sd_data_q;

  assign wReadData = !wReadEnable ? 32'hzzzzzzzz :
                     sel_ctrl     ? {30'b0, done_q, busy} :
                     sel_sector   ? sd_addr_q :
                     sel_buf      ? bus_rdata :
                                    32'hzzzzzzzz;

endmodule

// File: tb/tb_sd_write_interface.sv
// Self-checking bench for sd_write_interface: register/buffer vectors plus full
// sector streams checked against a word-array model of the buffer.
module tb_sd_write_interface;
  import sd_if_pkg::*;

  logic        iCLK = 1'b0;
  logic        Reset;
  logic        wReadEnable, wWriteEnable;
  logic [3:0]  wByteEnable;
  logic [31:0] wAddress, wWriteData, wReadData, oSDAddress;
  logic        oSDWrite;
  logic [7:0]  oSDData;
  logic        iSDByteReq, iSDReady;

  int checks   = 0;
  int failures = 0;

  logic [31:0] model_buf [BUF_WORDS];

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp;
  } bus_vec_t;

  bus_vec_t vecs [6];

  sd_write_interface dut (
    .iCLK         (iCLK),
    .Reset        (Reset),
    .wReadEnable  (wReadEnable),
    .wWriteEnable (wWriteEnable),
    .wByteEnable  (wByteEnable),
    .wAddress     (wAddress),
    .wWriteData   (wWriteData),
    .wReadData    (wReadData),
    .oSDAddress   (oSDAddress),
    .oSDWrite     (oSDWrite),
    .oSDData      (oSDData),
    .iSDByteReq   (iSDByteReq),
    .iSDReady     (iSDReady)
  );

  always #5 iCLK = ~iCLK;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endfunction

  function automatic void model_write(input int idx, input logic [3:0] be, input logic [31:0] d);
    for (int l = 0; l < 4; l++) begin
      if (be[l]) model_buf[idx][8*l +: 8] = d[8*l +: 8];
    end
  endfunction

  function automatic logic [7:0] exp_byte(input int i);
    logic [31:0] w;
    w = model_buf[i / 4];
    return w[8*(i % 4) +: 8];
  endfunction

  task automatic bus_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    @(negedge iCLK);
    wWriteEnable = 1'b1;
    wAddress     = a;
    wByteEnable  = be;
    wWriteData   = d;
    @(negedge iCLK);
    wWriteEnable = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge iCLK);
    wReadEnable = 1'b1;
    wAddress    = a;
    @(negedge iCLK);
    d = wReadData;
    wReadEnable = 1'b0;
  endtask

  task automatic buf_write(input int idx, input logic [3:0] be, input logic [31:0] d);
    bus_write(BUF_BASE + 32'(idx * 4), be, d);
    model_write(idx, be, d);
  endtask

  task automatic check_unmapped(input string name);
    logic [31:0] d;
    bus_read(32'h12345670, d);
    checks++;
    // The simulator may resolve an undriven bus to zero instead of Z.
    if (!(d === 32'hzzzzzzzz || d === 32'h0)) begin
      failures++;
      $display("FAIL %s: got %h, required zzzzzzzz", name, d);
    end
  endtask

  // Acts as the controller: takes bytes with a 2..4 cycle spacing.
  task automatic stream_sector(input int stop_after, input bit inject);
    int bad = 0;
    int first_bad = -1;
    for (int c = 0; c < 100 && oSDWrite !== 1'b1; c++) @(negedge iCLK);
    check("stream_start", {31'b0, oSDWrite}, 32'd1);
    for (int i = 0; i < stop_after; i++) begin
      if (oSDData !== exp_byte(i) || oSDWrite !== 1'b1) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
      iSDByteReq = 1'b1;
      @(negedge iCLK);
      iSDByteReq = 1'b0;
      if (inject && i == 50) begin
        wWriteEnable = 1'b1;
        wByteEnable  = 4'hF;
        wAddress     = BUF_BASE + 32'(60 * 4);
        wWriteData   = 32'h5A5A5A5A;
        @(negedge iCLK);
        wAddress     = SECTOR_ADDR;
        wWriteData   = 32'h00000099;
        @(negedge iCLK);
        wAddress     = CTRL_ADDR;
        wWriteData   = 32'h00000001;
        @(negedge iCLK);
        wWriteEnable = 1'b0;
      end
      if (i != stop_after - 1) repeat ($urandom_range(1, 3)) @(negedge iCLK);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL stream_bytes: got %0d bad bytes (first at %0d), required 0", bad, first_bad);
    end
    if (stop_after == SECTOR_BYTES) begin
      check("flush_wr_low", {31'b0, oSDWrite}, 32'd0);
    end
    $display("stream: %0d bytes sent to sector %h", stop_after, oSDAddress);
  endtask

  task automatic flush_and_finish();
    logic [31:0] d;
    iSDReady = 1'b0;
    repeat (4) @(negedge iCLK);
    bus_read(CTRL_ADDR, d);
    check("flush_busy", d, 32'h1);
    iSDReady = 1'b1;
    d = 32'h1;
    for (int c = 0; c < 50 && d[0] == 1'b1; c++) bus_read(CTRL_ADDR, d);
    check("done_status", d, 32'h2);
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  kb;
    int          hold_bad;

    Reset = 1'b1; wReadEnable = 1'b0; wWriteEnable = 1'b0; wByteEnable = 4'h0;
    wAddress = 32'h0; wWriteData = 32'h0; iSDByteReq = 1'b0; iSDReady = 1'b1;
    for (int k = 0; k < BUF_WORDS; k++) model_buf[k] = 32'h0;
    repeat (3) @(negedge iCLK);
    Reset = 1'b0;

    // 1: reset state
    check("rst_wr", {31'b0, oSDWrite}, 32'd0);
    check("rst_data", {24'b0, oSDData}, 32'hFF);
    check("rst_addr", oSDAddress, 32'h0);
    bus_read(CTRL_ADDR, d);
    check("rst_ctrl", d, 32'h0);
    check_unmapped("rst_unmapped");

    // Register and byte-lane vectors (write, then read back)
    vecs[0] = '{"sector_rw",  SECTOR_ADDR,             4'hF, 32'h12345678, 32'h12345678};
    vecs[1] = '{"buf0_clear", BUF_BASE,                4'hF, 32'h00000000, 32'h00000000};
    vecs[2] = '{"buf0_lane1", BUF_BASE,                4'h2, 32'hAABBCCDD, 32'h0000CC00};
    vecs[3] = '{"buf0_lane0", BUF_BASE,                4'h1, 32'h11223344, 32'h0000CC44};
    vecs[4] = '{"buf_last",   BUF_BASE + 32'h1FC,      4'hF, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[5] = '{"buf_last_hi",BUF_BASE + 32'h1FC,      4'hC, 32'h12340000, 32'h1234BEEF};
    for (int v = 0; v < 6; v++) begin
      bus_write(vecs[v].addr, vecs[v].be, vecs[v].wdata);
      bus_read(vecs[v].addr, d);
      check(vecs[v].name, d, vecs[v].exp);
      $display("vec %s: addr %h be %h wrote %h read %h", vecs[v].name, vecs[v].addr,
               vecs[v].be, vecs[v].wdata, d);
    end
    bus_write(CTRL_ADDR, 4'hF, 32'h0);
    bus_read(CTRL_ADDR, d);
    check("ctrl_no_start", d, 32'h0);

    // 2: pattern fill, full sector stream
    for (int k = 0; k < BUF_WORDS; k++) begin
      kb = 8'(k);
      buf_write(k, 4'hF, {4{kb}} + 32'h03020100);
    end
    bus_write(SECTOR_ADDR, 4'hF, 32'h10);
    bus_write(CTRL_ADDR, 4'hF, 32'h1);
    stream_sector(SECTOR_BYTES, 1'b0);
    check("sector_out", oSDAddress, 32'h10);
    flush_and_finish();
    check_unmapped("done_unmapped");

    // 4: random contents, controller not ready for 20 cycles after START
    for (int k = 0; k < BUF_WORDS; k++) buf_write(k, 4'hF, $urandom);
    for (int n = 0; n < 20; n++) buf_write($urandom_range(0, BUF_WORDS - 1), 4'($urandom), $urandom);
    bus_read(BUF_BASE + 32'(7 * 4), d);
    check("buf_rand_rd", d, model_buf[7]);
    iSDReady = 1'b0;
    bus_write(CTRL_ADDR, 4'hF, 32'h1);
    hold_bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge iCLK);
      if (oSDWrite !== 1'b0) hold_bad++;
    end
    check("wait_rdy_hold", 32'(hold_bad), 32'd0);
    bus_read(CTRL_ADDR, d);
    check("wait_rdy_busy", d, 32'h1);
    iSDReady = 1'b1;
    stream_sector(SECTOR_BYTES, 1'b0);
    flush_and_finish();

    // 5: writes and START while busy are dropped
    bus_write(CTRL_ADDR, 4'hF, 32'h1);
    stream_sector(SECTOR_BYTES, 1'b1);
    flush_and_finish();
    check("busy_sector_kept", oSDAddress, 32'h10);
    bus_read(BUF_BASE + 32'(60 * 4), d);
    check("busy_buf_kept", d, model_buf[60]);

    // 6: reset mid-stream aborts, new START restarts at byte 0
    bus_write(CTRL_ADDR, 4'hF, 32'h1);
    stream_sector(100, 1'b0);
    Reset = 1'b1;
    @(negedge iCLK);
    check("abort_wr", {31'b0, oSDWrite}, 32'd0);
    Reset = 1'b0;
    check("abort_data", {24'b0, oSDData}, 32'hFF);
    check("abort_addr", oSDAddress, 32'h0);
    bus_read(CTRL_ADDR, d);
    check("abort_ctrl", d, 32'h0);
    bus_write(CTRL_ADDR, 4'hF, 32'h1);
    stream_sector(SECTOR_BYTES, 1'b0);
    flush_and_finish();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

endmodule
